div: RTL and testbench
======================

Name: div

Overview:
- Multi-cycle 32-bit divider serving the execute stage.
- EX drives DIV/DIVU operands and holds start_i while the pipeline is stalled.
- The divider returns {remainder, quotient} with a ready flag; EX routes it to HI/LO.
- Uses radix-2 restoring trial subtraction, one quotient bit per clock, with an optional early-exit path.

Parameters:
- DATA_W, 32: operand width; must equal the register-bus width. The iteration count equals DATA_W.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  reset, synchronous, active-high (RstEnable = 1'b1)
- signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU)
- opdata1_i  input  32  dividend
- opdata2_i  input  32  divisor
- start_i  input  1  request; held high by EX until it sees ready_o
- annul_i  input  1  cancel in-flight division (flush)
- result_o  output  64  {remainder[31:0], quotient[31:0]}
- ready_o  output  1  result valid

Behaviour:
- Reset:
  - rst high at a clock edge → state DivFree, cnt=0, result_o=0, ready_o=0.
  - Applies mid-operation; the partial result is discarded.
- State machine (2-bit) with states DivFree, DivByZero, DivOn, DivEnd.
- DivFree:
  - ready_o=0; result_o=0.
  - If start_i=1 and annul_i=0:
    - opdata2_i==0 → DivByZero.
    - Otherwise → DivOn. Latch abs(op1) and abs(op2) when signed_div_i=1 (two's-complement negate if bit31 set), else latch raw. Latch signed_div_i, op1[31] and op2[31] for the sign fix. dividend[64:0]={32'b0, |op1|, 1'b0}; cnt=0.
  - start_i=0 → stay in DivFree.
- DivByZero (next edge) → DivEnd with result 64'b0.
- DivOn, for cnt 0..31:
  - Compute diff = dividend[63:32] − divisor (33-bit).
  - Borrow → dividend <<= 1.
  - No borrow → dividend = {diff[31:0], dividend[31:0], 1'b1}.
  - cnt++.
- DivOn, at cnt==32:
  - quotient = dividend[31:0]; remainder = dividend[64:33].
  - Signed only: negate quotient if op1[31]^op2[31]; negate remainder if op1[31].
  - Register the result; → DivEnd.
- annul_i=1 in DivOn → DivFree next edge, no result.
- annul_i is ignored in DivFree and DivEnd.
- DivEnd:
  - ready_o=1; result_o holds the final value.
  - start_i=0 → DivFree next edge (ready_o=0, result_o=0).
  - start_i=1 → stay in DivEnd, result stable.
- Latency, with the start_i edge as E0:
  - Normal division: ready_o high after E33 (34 cycles start-to-ready, inclusive).
  - Divide-by-zero: ready_o high after E1.
- Operands are sampled only at the DivFree→DivOn edge. Operand changes during DivOn are ignored.
- Overflow (0x80000000 / −1, signed): quotient wraps to 0x80000000, remainder 0. No trap.
- Simultaneous start_i and rst: rst wins.

Optional Feature:
- Macro: DIV_EARLY_EXIT_EN.
- Defined:
  - In DivFree, when latched |op1| < |op2| (unsigned compare, divisor nonzero), go → DivByZero-style 1-cycle path to DivEnd.
  - Result there is quotient 0, remainder = original opdata1_i (sign preserved).
  - ready_o high after E1.
- Undefined: such operands take the full 32 iterations and give an identical result.

Decomposition:
- defines.v (shared) gains:
  - state codes DivFree 2'b00, DivByZero 2'b01, DivOn 2'b10, DivEnd 2'b11
  - DivResultReady/NotReady, DivStart/DivStop
  - a 64-bit DoubleRegBus width macro
- No sub-module. The single iteration step stays inline; a separate step module adds ports without reuse.

Test Plan:
- Unsigned 100 / 7 with start_i held → ready_o high at cycle 34, result_o = {32'd2, 32'd14}. Drop start_i → ready_o=0 next cycle.
- Signed −7 / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7 / −2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- Divisor 0 (any dividend, either mode) → ready_o at cycle 2, result_o = 0.
- Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0. Unsigned 0xFFFFFFFF / 1 → quotient 0xFFFFFFFF, remainder 0.
- annul_i pulse at cycle 10 of DivOn → DivFree, ready_o never asserts. A new start of 9/3 then gives quotient 3, remainder 0 at cycle 34.
- rst asserted at cycle 20 of DivOn → next cycle ready_o=0, result_o=0, DivFree. With DIV_EARLY_EXIT_EN, unsigned 5/9 → ready_o at cycle 2, result {5, 0}.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the multi-cycle divider: state codes, widths and
// ready/start encodings used by the execute stage.
package div_pkg;

   localparam int DATA_W   = 32;
   localparam int DOUBLE_W = 2 * DATA_W;
   localparam int CNT_W    = 6;

   localparam logic DIV_RESULT_READY     = 1'b1;
   localparam logic DIV_RESULT_NOT_READY = 1'b0;
   localparam logic DIV_START            = 1'b1;
   localparam logic DIV_STOP             = 1'b0;

   typedef enum logic [1:0] {
      DIV_FREE    = 2'b00,
      DIV_BY_ZERO = 2'b01,
      DIV_ON      = 2'b10,
      DIV_END     = 2'b11
   } div_state_t;

   // Two's-complement magnitude of a value when signed mode is selected.
   function automatic logic [DATA_W-1:0] div_abs(input logic sgn, input logic [DATA_W-1:0] v);
      return (sgn && v[DATA_W-1]) ? (~v + 1'b1) : v;
   endfunction

endpackage

// File: rtl/div.sv
// Radix-2 restoring divider, one quotient bit per clock.
// Returns {remainder, quotient}; ready_o stays high while start_i is held.
// Optional: define DIV_EARLY_EXIT_EN to finish in one cycle when
// |dividend| < |divisor| (quotient 0, remainder = original dividend).
//
// state       | meaning
// DIV_FREE    | idle, waiting for start_i
// DIV_BY_ZERO | one-cycle shortcut (zero divisor or early exit)
// DIV_ON      | iterating, r_cnt counts 0..32
// DIV_END     | result valid, held until start_i drops
module div
   import div_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                signed_div_i,
   input  logic [DATA_W-1:0]   opdata1_i,
   input  logic [DATA_W-1:0]   opdata2_i,
   input  logic                start_i,
   input  logic                annul_i,
   output logic [DOUBLE_W-1:0] result_o,
   output logic                ready_o
);

   div_state_t          r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic [DOUBLE_W:0]   r_dividend;
   logic [DATA_W-1:0]   r_divisor;
   logic                r_neg_q;
   logic                r_neg_r;
   logic                r_early;
   logic [DOUBLE_W-1:0] r_result;
   logic                r_ready;

   logic [DATA_W-1:0]   w_abs1;
   logic [DATA_W-1:0]   w_abs2;
   logic [DATA_W:0]     w_diff;
   logic [DATA_W-1:0]   w_quot;
   logic [DATA_W-1:0]   w_rem;

   // Operand magnitudes, trial subtraction and sign-corrected final values.
   always_comb begin
      w_abs1 = div_abs(signed_div_i, opdata1_i);
      w_abs2 = div_abs(signed_div_i, opdata2_i);
      w_diff = {1'b0, r_dividend[DOUBLE_W-1:DATA_W]} - {1'b0, r_divisor};
      w_quot = r_neg_q ? (~r_dividend[DATA_W-1:0] + 1'b1) : r_dividend[DATA_W-1:0];
      w_rem  = r_neg_r ? (~r_dividend[DOUBLE_W:DATA_W+1] + 1'b1) : r_dividend[DOUBLE_W:DATA_W+1];
   end

   // Sequencing FSM with registered result and ready flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= DIV_FREE;
         r_cnt      <= '0;
         r_dividend <= '0;
         r_divisor  <= '0;
         r_neg_q    <= 1'b0;
         r_neg_r    <= 1'b0;
         r_early    <= 1'b0;
         r_result   <= '0;
         r_ready    <= DIV_RESULT_NOT_READY;
      end else begin
         case (r_state)
            DIV_FREE: begin
               r_ready  <= DIV_RESULT_NOT_READY;
               r_result <= '0;
               if (start_i == DIV_START && !annul_i) begin
                  if (opdata2_i == '0) begin
                     r_early <= 1'b0;
                     r_state <= DIV_BY_ZERO;
`ifdef DIV_EARLY_EXIT_EN
                  end else if (w_abs1 < w_abs2) begin
                     // Remainder is the raw dividend, parked in the low word.
                     r_early    <= 1'b1;
                     r_dividend <= {{(DATA_W+1){1'b0}}, opdata1_i};
                     r_state    <= DIV_BY_ZERO;
`endif
                  end else begin
                     r_early    <= 1'b0;
                     r_dividend <= {{DATA_W{1'b0}}, w_abs1, 1'b0};
                     r_divisor  <= w_abs2;
                     r_neg_q    <= signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                     r_neg_r    <= signed_div_i & opdata1_i[DATA_W-1];
                     r_cnt      <= '0;
                     r_state    <= DIV_ON;
                  end
               end
            end
            DIV_BY_ZERO: begin
               r_result <= r_early ? {r_dividend[DATA_W-1:0], {DATA_W{1'b0}}} : '0;
               r_ready  <= DIV_RESULT_READY;
               r_state  <= DIV_END;
            end
            DIV_ON: begin
               if (annul_i) begin
                  r_state <= DIV_FREE;
               end else if (r_cnt != CNT_W'(DATA_W)) begin
                  if (w_diff[DATA_W])
                     r_dividend <= {r_dividend[DOUBLE_W-1:0], 1'b0};
                  else
                     r_dividend <= {w_diff[DATA_W-1:0], r_dividend[DATA_W-1:0], 1'b1};
                  r_cnt <= r_cnt + 1'b1;
               end else begin
                  r_result <= {w_rem, w_quot};
                  r_ready  <= DIV_RESULT_READY;
                  r_state  <= DIV_END;
               end
            end
            DIV_END: begin
               if (start_i == DIV_STOP) begin
                  r_ready  <= DIV_RESULT_NOT_READY;
                  r_result <= '0;
                  r_state  <= DIV_FREE;
               end
            end
            default: r_state <= DIV_FREE;
         endcase
      end
   end

   assign result_o = r_result;
   assign ready_o  = r_ready;

endmodule

// File: tb/tb_div.sv
// Directed bench for the multi-cycle divider. Cycle counts treat the edge
// that first sees start_i as cycle 1.
module tb_div;

   logic        clk = 1'b0;
   logic        rst;
   logic        signed_div_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic        start_i;
   logic        annul_i;
   logic [63:0] result_o;
   logic        ready_o;

   int n_checks = 0;
   int n_errors = 0;

   div u_dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .result_o     (result_o),
      .ready_o      (ready_o)
   );

   always #5 clk = ~clk;

   task automatic start_op(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      signed_div_i = sgn;
      opdata1_i    = a;
      opdata2_i    = b;
      start_i      = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(output int cyc, output logic [63:0] res);
      cyc = 1;
      while (!ready_o && cyc < 100) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      res = result_o;
   endtask

   task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output int cyc, output logic [63:0] res);
      start_op(sgn, a, b);
      wait_ready(cyc, res);
   endtask

   task automatic release_start;
      @(negedge clk);
      start_i = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (ready_o !== 1'b0 || result_o !== 64'd0) begin
         n_errors++;
         $display("FAIL reset: ready=%b result=%h want ready=0 result=0", ready_o, result_o);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_unsigned;
      int cyc;
      logic [63:0] res;
      do_div(1'b0, 32'd100, 32'd7, cyc, res);
      n_checks++;
      if (cyc !== 34) begin
         n_errors++;
         $display("FAIL udiv_latency: got %0d want 34", cyc);
      end
      n_checks++;
      if (res !== {32'd2, 32'd14}) begin
         n_errors++;
         $display("FAIL udiv_100_7: got %h want %h", res, {32'd2, 32'd14});
      end
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (ready_o !== 1'b1 || result_o !== {32'd2, 32'd14}) begin
         n_errors++;
         $display("FAIL udiv_hold: ready=%b result=%h want ready=1 result=%h", ready_o, result_o, {32'd2, 32'd14});
      end
      release_start();
      n_checks++;
      if (ready_o !== 1'b0 || result_o !== 64'd0) begin
         n_errors++;
         $display("FAIL udiv_drop: ready=%b result=%h want ready=0 result=0", ready_o, result_o);
      end
   endtask

   task automatic test_signed;
      int cyc;
      logic [63:0] res;
      do_div(1'b1, 32'hFFFF_FFF9, 32'd2, cyc, res);
      n_checks++;
      if (res !== {32'hFFFF_FFFF, 32'hFFFF_FFFD} || cyc !== 34) begin
         n_errors++;
         $display("FAIL sdiv_m7_2: got %h cyc %0d want %h cyc 34", res, cyc, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      end
      release_start();
      do_div(1'b1, 32'd7, 32'hFFFF_FFFE, cyc, res);
      n_checks++;
      if (res !== {32'h0000_0001, 32'hFFFF_FFFD}) begin
         n_errors++;
         $display("FAIL sdiv_7_m2: got %h want %h", res, {32'h0000_0001, 32'hFFFF_FFFD});
      end
      release_start();
   endtask

   task automatic test_div_zero;
      int cyc;
      logic [63:0] res;
      do_div(1'b0, 32'd12345, 32'd0, cyc, res);
      n_checks++;
      if (cyc !== 2 || res !== 64'd0) begin
         n_errors++;
         $display("FAIL divzero_u: cyc %0d result %h want cyc 2 result 0", cyc, res);
      end
      release_start();
      do_div(1'b1, 32'hFFFF_FFFB, 32'd0, cyc, res);
      n_checks++;
      if (cyc !== 2 || res !== 64'd0) begin
         n_errors++;
         $display("FAIL divzero_s: cyc %0d result %h want cyc 2 result 0", cyc, res);
      end
      release_start();
   endtask

   task automatic test_boundary;
      int cyc;
      logic [63:0] res;
      do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, cyc, res);
      n_checks++;
      if (res !== {32'd0, 32'h8000_0000}) begin
         n_errors++;
         $display("FAIL sdiv_overflow: got %h want %h", res, {32'd0, 32'h8000_0000});
      end
      release_start();
      do_div(1'b0, 32'hFFFF_FFFF, 32'd1, cyc, res);
      n_checks++;
      if (res !== {32'd0, 32'hFFFF_FFFF}) begin
         n_errors++;
         $display("FAIL udiv_max_1: got %h want %h", res, {32'd0, 32'hFFFF_FFFF});
      end
      release_start();
      do_div(1'b0, 32'hFFFF_FFFF, 32'h10, cyc, res);
      n_checks++;
      if (res !== {32'h0000_000F, 32'h0FFF_FFFF}) begin
         n_errors++;
         $display("FAIL udiv_max_16: got %h want %h", res, {32'h0000_000F, 32'h0FFF_FFFF});
      end
      release_start();
   endtask

   task automatic test_operand_hold;
      int cyc;
      logic [63:0] res;
      start_op(1'b0, 32'd100, 32'd7);
      opdata1_i = 32'hDEAD_BEEF;
      opdata2_i = 32'd3;
      signed_div_i = 1'b1;
      wait_ready(cyc, res);
      n_checks++;
      if (res !== {32'd2, 32'd14} || cyc !== 34) begin
         n_errors++;
         $display("FAIL operand_hold: got %h cyc %0d want %h cyc 34", res, cyc, {32'd2, 32'd14});
      end
      release_start();
   endtask

   task automatic test_annul;
      int cyc;
      int seen;
      logic [63:0] res;
      start_op(1'b0, 32'd100, 32'd7);
      repeat (9) @(posedge clk);
      @(negedge clk);
      annul_i = 1'b1;
      start_i = 1'b0;
      @(negedge clk);
      annul_i = 1'b0;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (ready_o || result_o != 64'd0) seen++;
      end
      n_checks++;
      if (seen !== 0) begin
         n_errors++;
         $display("FAIL annul_quiet: %0d cycles with output activity, want 0", seen);
      end
      do_div(1'b0, 32'd9, 32'd3, cyc, res);
      n_checks++;
      if (res !== {32'd0, 32'd3} || cyc !== 34) begin
         n_errors++;
         $display("FAIL annul_restart: got %h cyc %0d want %h cyc 34", res, cyc, {32'd0, 32'd3});
      end
      release_start();
   endtask

   task automatic test_mid_reset;
      int cyc;
      logic [63:0] res;
      start_op(1'b0, 32'd100, 32'd7);
      repeat (19) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if (ready_o !== 1'b0 || result_o !== 64'd0) begin
         n_errors++;
         $display("FAIL mid_reset: ready=%b result=%h want ready=0 result=0", ready_o, result_o);
      end
      @(negedge clk);
      rst = 1'b0;
      start_i = 1'b0;
      @(negedge clk);
      do_div(1'b0, 32'd9, 32'd3, cyc, res);
      n_checks++;
      if (res !== {32'd0, 32'd3} || cyc !== 34) begin
         n_errors++;
         $display("FAIL post_reset_div: got %h cyc %0d want %h cyc 34", res, cyc, {32'd0, 32'd3});
      end
      release_start();
   endtask

   task automatic test_early_exit;
      int cyc;
      int exp_cyc;
      logic [63:0] res;
`ifdef DIV_EARLY_EXIT_EN
      exp_cyc = 2;
`else
      exp_cyc = 34;
`endif
      do_div(1'b0, 32'd5, 32'd9, cyc, res);
      n_checks++;
      if (res !== {32'd5, 32'd0} || cyc !== exp_cyc) begin
         n_errors++;
         $display("FAIL small_udiv: got %h cyc %0d want %h cyc %0d", res, cyc, {32'd5, 32'd0}, exp_cyc);
      end
      release_start();
      do_div(1'b1, 32'hFFFF_FFFB, 32'd9, cyc, res);
      n_checks++;
      if (res !== {32'hFFFF_FFFB, 32'd0} || cyc !== exp_cyc) begin
         n_errors++;
         $display("FAIL small_sdiv: got %h cyc %0d want %h cyc %0d", res, cyc, {32'hFFFF_FFFB, 32'd0}, exp_cyc);
      end
      release_start();
   endtask

   initial begin
      rst          = 1'b1;
      signed_div_i = 1'b0;
      opdata1_i    = '0;
      opdata2_i    = '0;
      start_i      = 1'b0;
      annul_i      = 1'b0;
      test_reset();
      test_unsigned();
      test_signed();
      test_div_zero();
      test_boundary();
      test_operand_hold();
      test_annul();
      test_mid_reset();
      test_early_exit();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
